// File: rtl/settle_sequencer_pkg.sv
// settle_sequencer_pkg
// Shared definitions for the settle sequencer: FSM state encoding, default
// parameter values and the counter width used by the settle and timeout
// counters.
package settle_sequencer_pkg;

  localparam int SETTLE_CYCLES_DEF = 4;
  localparam int TIMEOUT_DEF       = 64;
  localparam int CNT_W             = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_START  = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  // Terminal count for a counter that starts at 0 and must see n cycles.
  function automatic logic [CNT_W-1:0] last_count(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/settle_sequencer_detect_input.sv
// detect_input
// Registers the raw operands every clock and flags any difference between
// the live inputs and their registered copies.
// Ports:
//   clk, rst        : clock, async active-low reset
//   a, b            : raw operand inputs
//   a_out, b_out    : operands registered every clock (reset to 0)
//   changed         : combinational, 1 when a or b differs from its copy
module detect_input (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] a_out,
  output logic [7:0] b_out,
  output logic       changed
);

  logic [7:0] r_a_q;
  logic [7:0] r_b_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_q <= 8'h00;
      r_b_q <= 8'h00;
    end else begin
      r_a_q <= a;
      r_b_q <= b;
    end
  end

  assign a_out   = r_a_q;
  assign b_out   = r_b_q;
  assign changed = (a != r_a_q) || (b != r_b_q);

endmodule

// File: rtl/settle_sequencer.sv
// settle_sequencer
// Waits for the operand inputs to hold still for SETTLE_CYCLES cycles, then
// latches them and launches a downstream unit with a one-cycle start pulse.
// Tracks the outstanding operation until done, with a sticky timeout error.
// Ports:
//   clk, rst          : clock, async active-low reset
//   a, b              : raw operands
//   done              : downstream completion pulse (honoured only in WAIT)
//   clr_err           : synchronous clear of err
//   start             : one-cycle launch pulse
//   op_a, op_b        : operands latched at launch
//   busy              : operation outstanding (START/WAIT)
//   err               : sticky timeout flag
//   done_cnt          : wrapping count of completed operations
//
// state  | meaning
// IDLE   | inputs quiet, nothing outstanding
// SETTLE | counting consecutive stable cycles
// START  | launch cycle, start=1
// WAIT   | waiting for done, timeout counter running
module settle_sequencer
  import settle_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int TIMEOUT       = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       done,
  input  logic       clr_err,
  output logic       start,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  output logic       busy,
  output logic       err,
  output logic [7:0] done_cnt
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = last_count(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST    = last_count(TIMEOUT);

  logic [7:0]       w_a_q;
  logic [7:0]       w_b_q;
  logic             w_changed;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_settle_cnt, w_settle_cnt_nxt;
  logic [CNT_W-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
  logic             r_pending, w_pending_nxt;
  logic             r_start, w_start_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_err, w_err_nxt;
  logic [7:0]       r_op_a, w_op_a_nxt;
  logic [7:0]       r_op_b, w_op_b_nxt;
  logic [7:0]       r_done_cnt, w_done_cnt_nxt;
  logic             w_exit_wait;

  detect_input u_detect (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .a_out   (w_a_q),
    .b_out   (w_b_q),
    .changed (w_changed)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
      r_tmo_cnt    <= '0;
      r_pending    <= 1'b0;
      r_start      <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_op_a       <= 8'h00;
      r_op_b       <= 8'h00;
      r_done_cnt   <= 8'h00;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
      r_tmo_cnt    <= w_tmo_cnt_nxt;
      r_pending    <= w_pending_nxt;
      r_start      <= w_start_nxt;
      r_busy       <= w_busy_nxt;
      r_err        <= w_err_nxt;
      r_op_a       <= w_op_a_nxt;
      r_op_b       <= w_op_b_nxt;
      r_done_cnt   <= w_done_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_settle_cnt_nxt = r_settle_cnt;
    w_tmo_cnt_nxt    = r_tmo_cnt;
    w_pending_nxt    = r_pending;
    w_err_nxt        = r_err;
    w_op_a_nxt       = r_op_a;
    w_op_b_nxt       = r_op_b;
    w_done_cnt_nxt   = r_done_cnt;
    w_exit_wait      = 1'b0;

    // A timeout below overrides this, so a coinciding clear leaves err set.
    if (clr_err) w_err_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_changed) begin
          w_state_nxt      = ST_SETTLE;
          w_settle_cnt_nxt = '0;
          w_pending_nxt    = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (w_changed) begin
          w_settle_cnt_nxt = '0;
        end else if (r_settle_cnt == SETTLE_LAST) begin
          w_state_nxt = ST_START;
          // changed=0 here, so the registered copies equal the live inputs.
          w_op_a_nxt  = w_a_q;
          w_op_b_nxt  = w_b_q;
        end else begin
          w_settle_cnt_nxt = r_settle_cnt + 1'b1;
        end
      end
      ST_START: begin
        if (w_changed) w_pending_nxt = 1'b1;
        w_state_nxt   = ST_WAIT;
        w_tmo_cnt_nxt = '0;
      end
      ST_WAIT: begin
        if (w_changed) w_pending_nxt = 1'b1;
        // done wins over a same-cycle timeout.
        if (done) begin
          w_done_cnt_nxt = r_done_cnt + 8'd1;
          w_exit_wait    = 1'b1;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_err_nxt   = 1'b1;
          w_exit_wait = 1'b1;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
        end
        if (w_exit_wait) begin
          if (r_pending || w_changed) begin
            w_state_nxt      = ST_SETTLE;
            w_settle_cnt_nxt = '0;
            w_pending_nxt    = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_start_nxt = (w_state_nxt == ST_START);
    w_busy_nxt  = (w_state_nxt == ST_START) || (w_state_nxt == ST_WAIT);
  end

  assign start    = r_start;
  assign busy     = r_busy;
  assign err      = r_err;
  assign op_a     = r_op_a;
  assign op_b     = r_op_b;
  assign done_cnt = r_done_cnt;

endmodule

// File: tb/tb_settle_sequencer.sv
// tb_settle_sequencer
// Self-checking bench for settle_sequencer (SETTLE_CYCLES=4, TIMEOUT=64).
// Expected launches (operands and launch cycle) are queued as stimulus is
// applied and compared by a monitor whenever start is seen.
module tb_settle_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       done = 1'b0;
  logic       clr_err = 1'b0;
  logic       start;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       busy;
  logic       err;
  logic [7:0] done_cnt;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         start_cnt = 0;
  logic [7:0] exp_cnt = 8'h00;

  settle_sequencer #(.SETTLE_CYCLES(4), .TIMEOUT(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .done     (done),
    .clr_err  (clr_err),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .err      (err),
    .done_cnt (done_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: every start must match the oldest queued launch.
  always @(negedge clk) begin
    if (rst && start) begin
      exp_t e;
      start_cnt = start_cnt + 1;
      checks = checks + 1;
      if (sb_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_start: cycle %0d op_a=%h op_b=%h, required no start", cyc, op_a, op_b);
      end else begin
        e = sb_q.pop_front();
        if (op_a !== e.a || op_b !== e.b || cyc !== e.cyc || busy !== 1'b1) begin
          errors = errors + 1;
          $display("FAIL launch: got op_a=%h op_b=%h cycle=%0d busy=%b, required op_a=%h op_b=%h cycle=%0d busy=1",
                   op_a, op_b, cyc, busy, e.a, e.b, e.cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply operands in the current cycle and queue the launch they should cause.
  task automatic drive_ops(input logic [7:0] a_v, input logic [7:0] b_v);
    exp_t e;
    a = a_v;
    b = b_v;
    e.a = a_v;
    e.b = b_v;
    e.cyc = cyc + 5;
    sb_q.push_back(e);
  endtask

  // Returns in the first WAIT cycle after the next start pulse.
  task automatic wait_start(input string name);
    int n0;
    int k;
    n0 = start_cnt;
    k = 0;
    while (start_cnt == n0 && k < 40) begin
      tick();
      k++;
    end
    if (start_cnt == n0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s_start_timeout: no start within 40 cycles, required a start", name);
    end
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    a = 8'h00;
    b = 8'h00;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({start, busy, err, op_a, op_b, done_cnt} !== 28'h0) begin
      errors++;
      $display("FAIL reset_outputs: start=%b busy=%b err=%b op_a=%h op_b=%h done_cnt=%h, required all 0",
               start, busy, err, op_a, op_b, done_cnt);
    end
    tick();
    rst = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    checks++;
    if (start_cnt !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_zero_inputs: starts=%0d busy=%b, required starts=0 busy=0", start_cnt, busy);
    end
  endtask

  task automatic test_basic();
    tick();
    drive_ops(8'h12, 8'h34);
    wait_start("basic");
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_wait: busy=%b, required 1", busy);
    end
    tick();
    pulse_done();
    exp_cnt++;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done_cnt !== exp_cnt || err !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: busy=%b done_cnt=%0d err=%b, required busy=0 done_cnt=%0d err=0",
               busy, done_cnt, err, exp_cnt);
    end
  endtask

  task automatic test_toggle();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 5) drive_ops(8'h02, 8'h34);
      else a = (i % 2 == 0) ? 8'h01 : 8'h02;
      if (i < 5) tick();
    end
    wait_start("toggle");
    pulse_done();
    exp_cnt++;
    @(negedge clk);
    checks++;
    if (done_cnt !== exp_cnt || busy !== 1'b0) begin
      errors++;
      $display("FAIL toggle_done: done_cnt=%0d busy=%b, required done_cnt=%0d busy=0", done_cnt, busy, exp_cnt);
    end
  endtask

  task automatic test_pending();
    exp_t e;
    tick();
    drive_ops(8'h02, 8'h00);
    wait_start("pend_first");
    tick();
    b = 8'h55;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if (op_b !== 8'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pend_hold_wait: op_b=%h busy=%b, required op_b=00 busy=1", op_b, busy);
    end
    tick();
    pulse_done();
    exp_cnt++;
    e.a = 8'h02;
    e.b = 8'h55;
    e.cyc = cyc + 4;
    sb_q.push_back(e);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL pend_done: busy=%b done_cnt=%0d, required busy=0 done_cnt=%0d", busy, done_cnt, exp_cnt);
    end
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (op_b !== 8'h00) begin
      errors++;
      $display("FAIL pend_hold_settle: op_b=%h, required 00", op_b);
    end
    wait_start("pend_second");
    pulse_done();
    exp_cnt++;
  endtask

  task automatic test_timeout();
    tick();
    drive_ops(8'h07, 8'h55);
    wait_start("tmo");
    repeat (63) tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_before: busy=%b err=%b, required busy=1 err=0", busy, err);
    end
    tick();
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || done_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL tmo_expire: err=%b busy=%b done_cnt=%0d, required err=1 busy=0 done_cnt=%0d",
               err, busy, done_cnt, exp_cnt);
    end
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_clr: err=%b, required 0", err);
    end

    tick();
    drive_ops(8'h08, 8'h55);
    wait_start("tmo_done");
    repeat (63) tick();
    pulse_done();
    exp_cnt++;
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || done_cnt !== exp_cnt || busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_with_done: err=%b done_cnt=%0d busy=%b, required err=0 done_cnt=%0d busy=0",
               err, done_cnt, busy, exp_cnt);
    end

    tick();
    drive_ops(8'h09, 8'h55);
    wait_start("tmo_clr");
    repeat (63) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_with_clr: err=%b, required 1", err);
    end
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    tick();
    drive_ops(8'h21, 8'h43);
    wait_start("rstmid");
    repeat (2) tick();
    #2;
    rst = 1'b0;
    exp_cnt = 8'h00;
    #1;
    checks++;
    if ({start, busy, err, op_a, op_b, done_cnt} !== 28'h0) begin
      errors++;
      $display("FAIL rstmid_async: start=%b busy=%b err=%b op_a=%h op_b=%h done_cnt=%h, required all 0",
               start, busy, err, op_a, op_b, done_cnt);
    end
    a = 8'h00;
    b = 8'h00;
    tick();
    rst = 1'b1;
    repeat (2) tick();
    pulse_done();
    repeat (10) tick();
    @(negedge clk);
    checks++;
    if (done_cnt !== 8'h00 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_done_ignored: done_cnt=%0d busy=%b err=%b, required 0 0 0", done_cnt, busy, err);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 256; i++) begin
      tick();
      drive_ops(8'(i) ^ 8'h80, 8'h00);
      wait_start("wrap");
      pulse_done();
      exp_cnt++;
      if (i == 254) begin
        @(negedge clk);
        checks++;
        if (done_cnt !== 8'd255) begin
          errors++;
          $display("FAIL wrap_255: done_cnt=%0d, required 255", done_cnt);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (done_cnt !== 8'd0 || exp_cnt !== 8'd0) begin
      errors++;
      $display("FAIL wrap_zero: done_cnt=%0d, required 0", done_cnt);
    end
  endtask

  task automatic test_release_nonzero();
    tick();
    rst = 1'b0;
    exp_cnt = 8'h00;
    tick();
    a = 8'h09;
    b = 8'h00;
    tick();
    rst = 1'b1;
    begin
      exp_t e;
      e.a = 8'h09;
      e.b = 8'h00;
      e.cyc = cyc + 5;
      sb_q.push_back(e);
    end
    wait_start("release");
    pulse_done();
    exp_cnt++;
    @(negedge clk);
    checks++;
    if (done_cnt !== exp_cnt || busy !== 1'b0) begin
      errors++;
      $display("FAIL release_done: done_cnt=%0d busy=%b, required done_cnt=%0d busy=0", done_cnt, busy, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_pending();
    test_timeout();
    test_reset_mid();
    test_wrap();
    test_release_nonzero();
    repeat (5) tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL missing_starts: %0d launches outstanding, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/settle_sequencer.md
SETTLE_SEQUENCER -- requirements
Module: settle_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, giving the consecutive stable cycles required before issue (legal range 1..255).
REQ-002 SHALL have parameter TIMEOUT, default 64, giving the maximum WAIT cycles without done before error (legal range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have ports a and b, input, 8 bits each: raw operand inputs.
REQ-006 SHALL have port done, input, 1 bit: downstream unit completion pulse.
REQ-007 SHALL have port clr_err, input, 1 bit: synchronous clear of err.
REQ-008 SHALL have port start, output, 1 bit: one-cycle launch pulse to the downstream unit.
REQ-009 SHALL have ports op_a and op_b, output, 8 bits each: latched operands for the downstream unit.
REQ-010 SHALL have port busy, output, 1 bit: operation outstanding.
REQ-011 SHALL have port err, output, 1 bit: sticky timeout flag.
REQ-012 SHALL have port done_cnt, output, 8 bits: count of completed operations.

Function
REQ-013 SHALL derive changed = (a != a_q) or (b != b_q) each cycle, where a_q and b_q are a and b registered every clock.
REQ-014 SHALL implement states IDLE, SETTLE, START and WAIT; all outputs registered.
REQ-015 In IDLE, changed=1 SHALL move to SETTLE with the settle counter at 0; otherwise the block stays in IDLE.
REQ-016 In SETTLE, the settle counter:
- changed=1: SHALL reset the counter to 0.
- changed=0: SHALL increment the counter.
- changed=0 with counter == SETTLE_CYCLES-1: SHALL move to START and latch op_a=a, op_b=b on that edge.
REQ-017 start SHALL be 1 for exactly the one cycle spent in START, then the block SHALL enter WAIT.
REQ-018 Issue latency: with inputs changed once then held, start SHALL assert SETTLE_CYCLES+1 cycles after the first cycle in which changed=1.
REQ-019 busy SHALL be 1 in START and WAIT and 0 in IDLE and SETTLE.
REQ-020 op_a and op_b SHALL hold their values from the START cycle until the next START.
REQ-021 changed=1 during START or WAIT SHALL set pending; pending SHALL clear on entry to SETTLE.
REQ-022 In WAIT, done=1 SHALL:
- increment done_cnt (wrapping 255->0);
- go to SETTLE if pending or changed is set that cycle, otherwise to IDLE.
REQ-023 A timeout counter SHALL count WAIT cycles; reaching TIMEOUT without done SHALL set err and exit WAIT as in REQ-022, without incrementing done_cnt.
REQ-024 done and timeout on the same cycle SHALL be treated as done; err SHALL NOT be set.
REQ-025 done outside WAIT SHALL be ignored and SHALL NOT change done_cnt.
REQ-026 err SHALL stay set until clr_err=1 or reset; a timeout coinciding with clr_err SHALL leave err=1.

Reset
REQ-027 rst=0 SHALL asynchronously force:
- state=IDLE;
- start=0, busy=0, err=0, pending=0;
- op_a, op_b, a_q, b_q, done_cnt and all counters to 0.
REQ-028 Reset mid-operation SHALL abandon the operation; a later done SHALL be ignored per REQ-025.
REQ-029 Nonzero a or b at reset release SHALL produce changed=1 and start settling.

Structure
REQ-030 A shared package SHALL hold the state enum and the SETTLE_CYCLES and TIMEOUT defaults.
REQ-031 Change detection SHALL instantiate the existing detect_input block (registered a_out/b_out, combinational changed) as the single sub-module.

Verification
REQ-032 Reset release with a=0x00, b=0x00, held -> state remains IDLE, start never asserts.
REQ-033 a=0x12, b=0x34 applied at cycle 0 and held, SETTLE_CYCLES=4 -> start=1 at cycle 5 with op_a=0x12, op_b=0x34; done at cycle 9 -> busy=0, done_cnt=1.
REQ-034 a toggles 0x01/0x02 every 2 cycles for 10 cycles, then holds 0x02 -> no start during toggling; start asserts 5 cycles after the last change with op_a=0x02.
REQ-035 b changed 0x00->0x55 during WAIT, then done -> next state SETTLE; second start with op_b=0x55; op_b unchanged until then.
REQ-036 No done for 64 WAIT cycles -> err=1, busy=0, done_cnt unchanged; done and timeout on the same cycle -> err=0; clr_err pulse -> err=0.
REQ-037 Reset asserted mid-WAIT, then done pulsed after release -> all outputs 0, done_cnt stays 0; 256 completions -> done_cnt wraps to 0.
